// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave cooking-time controller.
package microwave_pkg;
    localparam int BCD_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COOK  = ST_COOK,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/microwave_timer_ctrl_digit.sv
// One BCD display digit that counts down with wrap to MAX and a borrow to the next digit.
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    output logic             borrow_out,
    output logic [BCD_W-1:0] digit
);
    // Borrow is combinational so the whole MM:SS chain ripples on one edge.
    assign borrow_out = dec && (digit == '0);

    always_ff @(posedge clk) begin
        if (reset)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (dec)
            digit <= (digit == '0) ? MAX : digit - 1'b1;
    end
endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cooking timer: keypad entry into MM:SS BCD, 1 s countdown, door interlock.
// Optional DONE beep is built when the DONE_BEEP_EN macro is defined.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int BEEP_TICKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             start,
    input  logic             stop,
    input  logic             door_open,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             magnetron,
    output logic             done,
    output logic [1:0]       state_o,
    output logic             beep
);
    localparam int CTR_W = $clog2(TICK_DIV);
    localparam logic [CTR_W-1:0] TICK_LAST = CTR_W'(TICK_DIV - 1);

    state_t state, state_nxt;
    logic [CTR_W-1:0] tick_ctr, tick_ctr_nxt;
    logic tick, cook_tick, load, is_zero, is_one, key_ok;
    // Index 3 = minute tens ... index 0 = second ones.
    logic [3:0][BCD_W-1:0] dig, load_val;
    logic [3:0] dec, borrow;
    logic borrow_unused;

    assign dec = {borrow[2:0], cook_tick};
    assign borrow_unused = borrow[3];

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_down_digit #(.MAX(i == 1 ? SEC_TENS_MAX : DIGIT_MAX)) u_dig (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_val   (load_val[i]),
            .dec        (dec[i]),
            .borrow_out (borrow[i]),
            .digit      (dig[i])
        );
    end

    assign tick    = (tick_ctr == TICK_LAST);
    assign is_zero = (dig == 16'h0000);
    assign is_one  = (dig == 16'h0001);
    // A digit shifted into sec_tens must stay a legal 0-5.
    assign key_ok  = key_valid && (key_digit <= DIGIT_MAX) && (dig[0] <= SEC_TENS_MAX);

    always_comb begin
        state_nxt    = state;
        tick_ctr_nxt = tick_ctr;
        load         = 1'b0;
        load_val     = dig;
        cook_tick    = 1'b0;
        case (state)
            IDLE: begin
                tick_ctr_nxt = '0;
                if (stop) begin
                    load     = 1'b1;
                    load_val = '0;
                end else if (start) begin
                    if (!is_zero && !door_open)
                        state_nxt = COOK;
                end else if (key_ok) begin
                    load     = 1'b1;
                    load_val = {dig[2:0], key_digit};
                end
            end
            COOK: begin
                if (stop || door_open) begin
                    state_nxt = PAUSE;
                end else if (tick) begin
                    tick_ctr_nxt = '0;
                    cook_tick    = 1'b1;
                    if (is_one)
                        state_nxt = DONE;
                end else begin
                    tick_ctr_nxt = tick_ctr + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_nxt    = IDLE;
                    tick_ctr_nxt = '0;
                    load         = 1'b1;
                    load_val     = '0;
                end else if (start && !door_open) begin
                    state_nxt = COOK;
                end
            end
            DONE: begin
`ifdef DONE_BEEP_EN
                tick_ctr_nxt = tick ? '0 : tick_ctr + 1'b1;
`else
                tick_ctr_nxt = '0;
`endif
                if (stop || start || key_valid) begin
                    state_nxt    = IDLE;
                    tick_ctr_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_ctr <= '0;
        end else begin
            state    <= state_nxt;
            tick_ctr <= tick_ctr_nxt;
        end
    end

`ifdef DONE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);
    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            beep_cnt <= '0;
        else if (state != DONE && state_nxt == DONE)
            beep_cnt <= BEEP_W'(BEEP_TICKS);
        else if (state == DONE && tick && beep_cnt != '0)
            beep_cnt <= beep_cnt - 1'b1;
    end

    assign beep = (state == DONE) && (beep_cnt != '0);
`else
    localparam int beep_ticks_unused = BEEP_TICKS;
    assign beep = 1'b0;
`endif

    assign min_tens  = dig[3];
    assign min_ones  = dig[2];
    assign sec_tens  = dig[1];
    assign sec_ones  = dig[0];
    assign magnetron = (state == COOK) && !door_open;
    assign done      = (state == DONE);
    assign state_o   = state;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench: a seconds-based reference model predicts every cycle's outputs.
module tb_microwave_timer_ctrl;
    localparam int TD = 4;
    localparam int BT = 3;

    logic clk = 1'b0;
    logic reset, key_valid, start, stop, door_open;
    logic [3:0] key_digit;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic magnetron, done, beep;
    logic [1:0] state_o;

    microwave_timer_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .door_open(door_open),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .magnetron(magnetron), .done(done), .state_o(state_o), .beep(beep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic        mag;
        logic        dn;
        logic [1:0]  st;
        logic        bp;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: time held as total seconds, state as 0..3.
    int m_secs = 0, m_state = 0, m_ctr = 0, m_beep = 0;
    logic door_lvl = 1'b0;

    function automatic exp_t expect_now(logic door);
        exp_t e;
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        e.digits = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        e.mag    = (m_state == 1) && !door;
        e.dn     = (m_state == 3);
        e.st     = 2'(m_state);
`ifdef DONE_BEEP_EN
        e.bp     = (m_state == 3) && (m_beep > 0);
`else
        e.bp     = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_step(bit rst, bit kv, int kd, bit st, bit sp, bit door);
        int mm, ss;
        if (rst) begin
            m_secs = 0; m_state = 0; m_ctr = 0; m_beep = 0;
            return;
        end
        case (m_state)
            0: begin
                if (sp) m_secs = 0;
                else if (st) begin
                    if (m_secs != 0 && !door) begin m_state = 1; m_ctr = 0; end
                end else if (kv) begin
                    mm = m_secs / 60;
                    ss = m_secs % 60;
                    if (kd <= 9 && (ss % 10) <= 5)
                        m_secs = ((mm % 10) * 10 + ss / 10) * 60 + (ss % 10) * 10 + kd;
                end
            end
            1: begin
                if (sp || door) m_state = 2;
                else if (m_ctr == TD - 1) begin
                    m_ctr = 0;
                    m_secs--;
                    if (m_secs == 0) begin m_state = 3; m_beep = BT * TD; end
                end else m_ctr++;
            end
            2: begin
                if (sp) begin m_state = 0; m_secs = 0; m_ctr = 0; end
                else if (st && !door) m_state = 1;
            end
            default: begin
                if (sp || st || kv) begin m_state = 0; m_beep = 0; end
                else if (m_beep > 0) m_beep--;
            end
        endcase
    endtask

    task automatic cyc(bit rst, bit kv, int kd, bit st, bit sp, bit door);
        @(negedge clk);
        reset = rst; key_valid = kv; key_digit = 4'(kd);
        start = st; stop = sp; door_open = door;
        q.push_back(expect_now(door));
        model_step(rst, kv, kd, st, sp, door);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(int d);
        cyc(0, 1, d, 0, 0, 0);
    endtask

    task automatic go();
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    task automatic halt();
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                act = {min_tens, min_ones, sec_tens, sec_ones, magnetron, done, state_o, beep};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got digits=%h mag=%b done=%b state=%0d beep=%b, want digits=%h mag=%b done=%b state=%0d beep=%b",
                             $time, act.digits, act.mag, act.dn, act.st, act.bp,
                             e.digits, e.mag, e.dn, e.st, e.bp);
                end
            end
        end
    end

    initial begin
        int r, s, kd;
        reset = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop = 1'b0; door_open = 1'b0;
        model_step(1, 0, 0, 0, 0, 0);

        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        key(1); key(3); key(0); idle(1);
        go(); idle(5);
        halt(); halt();
        key(1); key(0); key(0); go(); idle(5);
        halt(); halt();
        key(1); key(0); key(0); key(0); go(); idle(5);
        halt(); halt();
        key(5); key(0); go(); idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
        idle(1); go(); idle(6);
        halt(); halt();
        key(1); go(); idle(4); idle(14);
        halt(); idle(2);
        key(1); go(); idle(6); key(2); idle(2);
        key(0); key(7); key(4); key(12); idle(1);
        halt(); go(); idle(1);
        key(3); cyc(0, 0, 0, 1, 0, 1); idle(1);
        key(5); go(); idle(2); cyc(1, 0, 0, 0, 0, 0); idle(2);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 299);
            s = $urandom_range(0, 99);
            kd = $urandom_range(0, 11);
            if (m_state == 1 || m_state == 2) begin
                if ($urandom_range(0, 19) == 0) door_lvl = ~door_lvl;
            end else door_lvl = 1'b0;
            if (r == 0)      cyc(1, 0, 0, 0, 0, door_lvl);
            else if (s < 25) cyc(0, 1, kd, 0, 0, door_lvl);
            else if (s < 33) cyc(0, 0, 0, 1, 0, door_lvl);
            else if (s < 36) cyc(0, 0, 0, 0, 1, door_lvl);
            else             cyc(0, 0, 0, 0, 0, door_lvl);
        end
        idle(2);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
